// File: rtl/contador_regresivo.sv
// Loadable N-bit down counter with a one-cycle terminal-count pulse and optional auto-reload.
// The count is presented on a 6-bit zero-extended bus shared with the up-counting Contador.
module contador_regresivo #(
    parameter int unsigned N           = 4,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic [5:0]   out,
    output logic         zero,
    output logic         done,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e         state_q;
    logic [N-1:0]   count_q;
    logic [N-1:0]   reload_q;

    // NOTE: all state is updated with non-blocking assignments so every register samples
    // pre-edge values; the async reset clears count and reload value as well as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
        end else if (load) begin
            count_q  <= load_value;
            reload_q <= load_value;
            state_q  <= (load_value == '0) ? DONE : COUNT;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                COUNT: begin
                    if (enable) begin
                        count_q <= count_q - N'(1);
                        if (count_q == N'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Reload value of zero never restarts the loop.
                    if (AUTO_RELOAD && (reload_q != '0)) begin
                        count_q <= reload_q;
                        state_q <= COUNT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out  = 6'(count_q);
    assign zero = (count_q == '0);
    assign done = (state_q == DONE);
    assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_contador_regresivo.sv
// Self-checking bench: three counter variants (N=4, N=6, N=4 auto-reload) driven in lockstep
// and compared each cycle against an arithmetic reference model.
module tb_contador_regresivo;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       load;
    logic [5:0] lv;

    logic [5:0] o_out  [3];
    logic       o_zero [3];
    logic       o_done [3];
    logic       o_busy [3];

    int n_pass;
    int n_total;

    // Reference model: remaining count, last loaded value, running / just-finished flags.
    int m_cnt [3];
    int m_rld [3];
    bit m_run [3];
    bit m_fin [3];

    contador_regresivo #(.N(4), .AUTO_RELOAD(1'b0)) u_n4 (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(lv[3:0]),
        .out(o_out[0]), .zero(o_zero[0]), .done(o_done[0]), .busy(o_busy[0])
    );

    contador_regresivo #(.N(6), .AUTO_RELOAD(1'b0)) u_n6 (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(lv),
        .out(o_out[1]), .zero(o_zero[1]), .done(o_done[1]), .busy(o_busy[1])
    );

    contador_regresivo #(.N(4), .AUTO_RELOAD(1'b1)) u_ar (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .load_value(lv[3:0]),
        .out(o_out[2]), .zero(o_zero[2]), .done(o_done[2]), .busy(o_busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int maxv(input int i);
        return (i == 1) ? 63 : 15;
    endfunction

    function automatic bit autoreload(input int i);
        return (i == 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_rld[i] = 0;
            m_run[i] = 1'b0;
            m_fin[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load) begin
                    m_cnt[i] = int'(lv) & maxv(i);
                    m_rld[i] = m_cnt[i];
                    m_fin[i] = (m_cnt[i] == 0);
                    m_run[i] = (m_cnt[i] != 0);
                end else if (m_fin[i]) begin
                    m_fin[i] = 1'b0;
                    m_run[i] = autoreload(i) && (m_rld[i] != 0);
                    if (m_run[i]) m_cnt[i] = m_rld[i];
                end else if (m_run[i] && enable) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    if (m_cnt[i] == 0) begin
                        m_run[i] = 1'b0;
                        m_fin[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s[u%0d].out", tag, i), {2'b00, o_out[i]}, 8'(m_cnt[i]));
            chk($sformatf("%s[u%0d].zero", tag, i), {7'd0, o_zero[i]}, {7'd0, (m_cnt[i] == 0)});
            chk($sformatf("%s[u%0d].done", tag, i), {7'd0, o_done[i]}, {7'd0, m_fin[i]});
            chk($sformatf("%s[u%0d].busy", tag, i), {7'd0, o_busy[i]}, {7'd0, m_run[i]});
        end
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        lv      = '0;
        model_reset();
        #2;
        check_all("por");
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b1;
        ticks("idle_en", 2);

        // Basic countdown from 5.
        load = 1'b1; lv = 6'd5; enable = 1'b0;
        tick("load5");
        load = 1'b0; enable = 1'b1;
        ticks("count5", 7);

        // Hold with enable low, then resume.
        load = 1'b1; lv = 6'd3; enable = 1'b0;
        tick("load3");
        load = 1'b0;
        ticks("hold3", 4);
        enable = 1'b1;
        ticks("resume3", 5);

        // Load beats a simultaneous decrement; load of zero pulses done at once.
        load = 1'b1; lv = 6'd6;
        tick("load6");
        load = 1'b0;
        ticks("to4", 2);
        load = 1'b1; lv = 6'd9;
        tick("prio9");
        lv = 6'd0;
        tick("load0");
        load = 1'b0;
        ticks("after0", 3);

        // Max start value, no wrap past zero; N=6 copy counts 63.
        load = 1'b1; lv = 6'd63;
        tick("loadmax");
        load = 1'b0;
        ticks("runmax", 68);

        // Async reset mid-count.
        load = 1'b1; lv = 6'd7;
        tick("load7");
        load = 1'b0; enable = 1'b0;
        ticks("at7", 1);
        async_reset("rst_mid");
        tick("rst_hold");
        reset = 1'b1; enable = 1'b1;
        ticks("post_rst", 3);

        // Auto-reload loop of period 3, stopped by reset.
        load = 1'b1; lv = 6'd2;
        tick("load2");
        load = 1'b0;
        ticks("loop2", 9);
        async_reset("rst_loop");
        @(negedge clk);
        reset = 1'b1;
        ticks("loop_stop", 4);

        // Randomised traffic.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 63) == 0) begin
                async_reset("rnd_rst");
            end else begin
                reset = 1'b1;
            end
            load   = ($urandom_range(0, 7) == 0);
            enable = ($urandom_range(0, 3) != 0);
            lv     = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            tick("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
